// File: rtl/sha_digest_collector.sv
// sha_digest_collector: captures one SHA2 and one SHA3 burst, then checks both against expected digests.
module sha_digest_collector #(
  parameter int DATA_W = 64,
  parameter int BEATS = 4,
  localparam int DW = DATA_W * BEATS,
  localparam int CW = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              clear,
  input  logic              sha2_valid,
  input  logic              sha3_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DW-1:0]     exp_sha2,
  input  logic [DW-1:0]     exp_sha3,
  output logic [DW-1:0]     sha2_digest,
  output logic [DW-1:0]     sha3_digest,
  output logic              sha2_got,
  output logic              sha3_got,
  output logic              done,
  output logic              sha2_match,
  output logic              sha3_match,
  output logic              auth_pass,
  output logic              err
);
  typedef enum logic [1:0] {COLLECT, CHECK, DONE, ERROR} state_t;
  state_t state_q;
  logic [DW-1:0] sha2_q, sha3_q;
  logic [CW-1:0] cnt_q, widx;
  logic act3_q, got2_q, got3_q, done_q, m2_q, m3_q, pass_q, err_q;
  logic act_v, oth_v, proto_err, beat, last;
  always_comb begin
    act_v = act3_q ? sha3_valid : sha2_valid;
    oth_v = act3_q ? sha2_valid : sha3_valid;
    proto_err = (sha2_valid & sha3_valid) | ((cnt_q != '0) & (~act_v | oth_v))
              | (sha2_valid & got2_q) | (sha3_valid & got3_q);
    beat = ~proto_err & (sha2_valid | sha3_valid);
    last = cnt_q == CW'(BEATS - 1);
    widx = CW'(BEATS - 1) - cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!srst_n || clear) begin
      state_q <= COLLECT;
      sha2_q  <= '0;
      sha3_q  <= '0;
      cnt_q   <= '0;
      act3_q  <= 1'b0;
      got2_q  <= 1'b0;
      got3_q  <= 1'b0;
      done_q  <= 1'b0;
      m2_q    <= 1'b0;
      m3_q    <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (proto_err) begin
            state_q <= ERROR;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (beat) begin
            // beat 0 lands in the most-significant word
            if (sha3_valid) sha3_q[widx*DATA_W +: DATA_W] <= data_in;
            else sha2_q[widx*DATA_W +: DATA_W] <= data_in;
            cnt_q  <= cnt_q + CW'(1);
            act3_q <= sha3_valid;
            if (last) begin
              got2_q <= got2_q | sha2_valid;
              got3_q <= got3_q | sha3_valid;
              if (sha3_valid ? got2_q : got3_q) state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          m2_q    <= sha2_q == exp_sha2;
          m3_q    <= sha3_q == exp_sha3;
          pass_q  <= (sha2_q == exp_sha2) && (sha3_q == exp_sha3);
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: ;
      endcase
    end
  end
  assign sha2_digest = sha2_q;
  assign sha3_digest = sha3_q;
  assign sha2_got    = got2_q;
  assign sha3_got    = got3_q;
  assign done        = done_q;
  assign sha2_match  = m2_q;
  assign sha3_match  = m3_q;
  assign auth_pass   = pass_q;
  assign err         = err_q;
endmodule

// File: tb/tb_sha_digest_collector.sv
// tb_sha_digest_collector: directed checks of burst capture, compare results and protocol errors.
module tb_sha_digest_collector;
  logic clk, srst_n, clear, sha2_valid, sha3_valid;
  logic [63:0] data_in;
  logic [255:0] exp_sha2, exp_sha3, sha2_digest, sha3_digest;
  logic sha2_got, sha3_got, done, sha2_match, sha3_match, auth_pass, err;
  int n_cmp = 0, n_bad = 0;
  localparam logic [255:0] D2 = {64'h1111111111111111, 64'h2222222222222222,
                                 64'h3333333333333333, 64'h4444444444444444};
  localparam logic [255:0] D3 = {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB,
                                 64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD};

  sha_digest_collector dut (
    .clk(clk), .srst_n(srst_n), .clear(clear), .sha2_valid(sha2_valid), .sha3_valid(sha3_valid),
    .data_in(data_in), .exp_sha2(exp_sha2), .exp_sha3(exp_sha3), .sha2_digest(sha2_digest),
    .sha3_digest(sha3_digest), .sha2_got(sha2_got), .sha3_got(sha3_got), .done(done),
    .sha2_match(sha2_match), .sha3_match(sha3_match), .auth_pass(auth_pass), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // inputs change at a falling edge and are sampled by the following rising edge
  task automatic drive(input logic v2, input logic v3, input logic [63:0] d);
    sha2_valid = v2;
    sha3_valid = v3;
    data_in = d;
    @(negedge clk);
  endtask

  task automatic burst(input logic s3, input logic [255:0] d);
    for (int k = 0; k < 4; k++) drive(!s3, s3, d[255-64*k -: 64]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(1'b0, 1'b0, 64'h0);
    clear = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_d2"}, sha2_digest, 256'h0);
    chk({tag, "_d3"}, sha3_digest, 256'h0);
    chk1({tag, "_got2"}, sha2_got, 1'b0);
    chk1({tag, "_got3"}, sha3_got, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_m2"}, sha2_match, 1'b0);
    chk1({tag, "_m3"}, sha3_match, 1'b0);
    chk1({tag, "_pass"}, auth_pass, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    srst_n = 1'b0; clear = 1'b0; sha2_valid = 1'b0; sha3_valid = 1'b0; data_in = '0;
    exp_sha2 = D2; exp_sha3 = D3;
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0);
    drive(1'b1, 1'b0, 64'h5);
    srst_n = 1'b1;
    chk_idle("reset");

    // SHA2 then SHA3, both matching
    burst(1'b0, D2);
    chk1("t1_got2", sha2_got, 1'b1);
    chk1("t1_got3_early", sha3_got, 1'b0);
    burst(1'b1, D3);
    chk1("t1_got3", sha3_got, 1'b1);
    chk1("t1_done_in_check", done, 1'b0);
    drive(1'b0, 1'b0, 64'h0);
    chk1("t1_done", done, 1'b1);
    chk("t1_d2", sha2_digest, D2);
    chk("t1_d3", sha3_digest, D3);
    chk1("t1_m2", sha2_match, 1'b1);
    chk1("t1_m3", sha3_match, 1'b1);
    chk1("t1_pass", auth_pass, 1'b1);
    chk1("t1_err", err, 1'b0);

    // extra burst while DONE is ignored
    burst(1'b0, D3);
    drive(1'b0, 1'b0, 64'h0);
    chk("t6_d2", sha2_digest, D2);
    chk1("t6_err", err, 1'b0);
    chk1("t6_pass", auth_pass, 1'b1);

    // clear, then repeat the passing run
    do_clear();
    chk_idle("t5_clear");
    burst(1'b0, D2);
    burst(1'b1, D3);
    drive(1'b0, 1'b0, 64'h0);
    chk1("t5_pass", auth_pass, 1'b1);
    chk1("t5_done", done, 1'b1);

    // SHA3 first, SHA2 back-to-back, SHA3 expectation off by one bit
    do_clear();
    exp_sha3 = D3 ^ 256'h1;
    burst(1'b1, D3);
    burst(1'b0, D2);
    drive(1'b0, 1'b0, 64'h0);
    chk("t2_d3", sha3_digest, D3);
    chk1("t2_m2", sha2_match, 1'b1);
    chk1("t2_m3", sha3_match, 1'b0);
    chk1("t2_pass", auth_pass, 1'b0);
    chk1("t2_err", err, 1'b0);
    chk1("t2_done", done, 1'b1);
    exp_sha3 = D3;

    // both valids together on beat 0
    do_clear();
    drive(1'b1, 1'b1, 64'h1111111111111111);
    chk1("t3_err", err, 1'b1);
    chk1("t3_done", done, 1'b1);
    chk("t3_d2", sha2_digest, 256'h0);
    chk("t3_d3", sha3_digest, 256'h0);
    chk1("t3_pass", auth_pass, 1'b0);

    // short SHA2 burst: error on the edge after beat 2
    do_clear();
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, D2[255-64*k -: 64]);
    chk1("t4a_err_early", err, 1'b0);
    drive(1'b0, 1'b0, 64'h0);
    chk1("t4a_err", err, 1'b1);
    chk("t4a_d2", sha2_digest, {D2[255:64], 64'h0});

    // over-length SHA2 burst: 5th beat errors and is not written
    do_clear();
    burst(1'b0, D2);
    chk1("t4b_err_early", err, 1'b0);
    drive(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF);
    chk1("t4b_err", err, 1'b1);
    chk("t4b_d2", sha2_digest, D2);
    chk1("t4b_m2", sha2_match, 1'b0);

    // SHA3 valid appearing mid-SHA2 burst
    do_clear();
    drive(1'b1, 1'b0, D2[255:192]);
    drive(1'b1, 1'b0, D2[191:128]);
    drive(1'b0, 1'b1, 64'hAAAAAAAAAAAAAAAA);
    chk1("intr_err", err, 1'b1);
    chk("intr_d3", sha3_digest, 256'h0);

    // reset during beat 2, then a fresh capture
    do_clear();
    drive(1'b1, 1'b0, D2[255:192]);
    drive(1'b1, 1'b0, D2[191:128]);
    srst_n = 1'b0;
    drive(1'b1, 1'b0, D2[127:64]);
    srst_n = 1'b1;
    drive(1'b0, 1'b0, 64'h0);
    chk_idle("t5_rst");
    burst(1'b1, D3);
    burst(1'b0, D2);
    drive(1'b0, 1'b0, 64'h0);
    chk("t5_rst_d2", sha2_digest, D2);
    chk1("t5_rst_pass", auth_pass, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
